mem_sram_port_arbiter: RTL and testbench



---
 rtl/mem_sram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_sram_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_port_arbiter.sv
// Round-robin arbiter folding NumPorts memory request ports onto one single-port SRAM
// macro, with a fixed-latency response pipeline that routes each result to its port.
package mem_sram_port_arbiter_pkg;
   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      logic        write;
   } mem_req_q_t;

   typedef struct packed {
      logic       q_valid;
      mem_req_q_t q;
   } mem_req_default_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] data;
   } mem_rsp_p_t;

   typedef struct packed {
      logic       q_ready;
      mem_rsp_p_t p;
   } mem_rsp_default_t;
endpackage

module mem_sram_port_arbiter
   import mem_sram_port_arbiter_pkg::*;
#(
   parameter type         mem_req_t     = mem_req_default_t,
   parameter type         mem_rsp_t     = mem_rsp_default_t,
   parameter int unsigned NumPorts      = 2,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned SramAddrWidth = 10,
   parameter int unsigned SramLatency   = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  mem_req_t [NumPorts-1:0]      mem_req_i,
   output mem_rsp_t [NumPorts-1:0]      mem_rsp_o,
   output logic                         sram_req_o,
   output logic                         sram_we_o,
   output logic [SramAddrWidth-1:0]     sram_addr_o,
   output logic [DataWidth-1:0]         sram_wdata_o,
   output logic [DataWidth/8-1:0]       sram_be_o,
   input  logic [DataWidth-1:0]         sram_rdata_i
);
   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned OffW      = $clog2(StrbWidth);
   localparam int unsigned PortIdW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   typedef struct packed {
      logic               valid;
      logic [PortIdW-1:0] port_id;
      logic               was_write;
   } pipe_entry_t;

   logic [NumPorts-1:0]           req_vec;
   logic [NumPorts-1:0]           gnt_onehot;
   logic                          grant_valid;
   logic [PortIdW-1:0]            grant_idx;
   logic [PortIdW-1:0]            last_grant_q, last_grant_d;
   pipe_entry_t [SramLatency-1:0] pipe_q, pipe_d;
   pipe_entry_t                   pipe_tail;
   logic [AddrWidth-1:0]          sel_addr;
   logic                          unused_sel_addr;

   always_comb begin
      req_vec = '0;
      for (int i = 0; i < NumPorts; i++) begin
         req_vec[i] = mem_req_i[i].q_valid & ~rst_i;
      end
   end

   // Ports above the pointer win first; the second pass wraps around to port 0.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NumPorts; i++) begin
         if (!grant_valid && req_vec[i] && (PortIdW'(i) > last_grant_q)) begin
            grant_valid = 1'b1;
            grant_idx   = PortIdW'(i);
         end
      end
      for (int i = 0; i < NumPorts; i++) begin
         if (!grant_valid && req_vec[i]) begin
            grant_valid = 1'b1;
            grant_idx   = PortIdW'(i);
         end
      end
      last_grant_d = grant_valid ? grant_idx : last_grant_q;
   end

   always_comb begin
      gnt_onehot = '0;
      for (int i = 0; i < NumPorts; i++) begin
         gnt_onehot[i] = grant_valid && (grant_idx == PortIdW'(i));
      end
   end

   always_comb begin
      sram_req_o   = grant_valid;
      sram_we_o    = 1'b0;
      sel_addr     = '0;
      sram_wdata_o = '0;
      sram_be_o    = '0;
      for (int i = 0; i < NumPorts; i++) begin
         if (gnt_onehot[i]) begin
            sram_we_o    = mem_req_i[i].q.write;
            sel_addr     = mem_req_i[i].q.addr;
            sram_wdata_o = mem_req_i[i].q.data;
            sram_be_o    = mem_req_i[i].q.write ? mem_req_i[i].q.strb : '1;
         end
      end
   end

   // Byte offset and the bits above the macro depth are dropped, so addresses alias.
   assign sram_addr_o     = sel_addr[SramAddrWidth+OffW-1:OffW];
   assign unused_sel_addr = ^sel_addr;

   always_comb begin
      pipe_d              = pipe_q;
      pipe_d[0].valid     = grant_valid;
      pipe_d[0].port_id   = grant_idx;
      pipe_d[0].was_write = sram_we_o;
      for (int i = 1; i < SramLatency; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_grant_q <= PortIdW'(NumPorts - 1);
         pipe_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         pipe_q       <= pipe_d;
      end
   end

   assign pipe_tail = pipe_q[SramLatency-1];

   // The tail entry lines up with the macro's read data, so it retires straight out.
   always_comb begin
      mem_rsp_o = '0;
      for (int i = 0; i < NumPorts; i++) begin
         mem_rsp_o[i].q_ready = gnt_onehot[i];
         if (pipe_tail.valid && !rst_i && (pipe_tail.port_id == PortIdW'(i))) begin
            mem_rsp_o[i].p.valid = 1'b1;
            mem_rsp_o[i].p.data  = pipe_tail.was_write ? '0 : sram_rdata_i;
         end
      end
   end

endmodule

// File: tb/tb_mem_sram_port_arbiter.sv
// Bench driving three arbiter instances (SRAM latency 1, 2, 3) with shared stimulus,
// a behavioural SRAM per instance, and a queue-based scoreboard per port.
module tb_mem_sram_port_arbiter;
   import mem_sram_port_arbiter_pkg::*;

   localparam int NumLat = 3;

   typedef struct {
      logic [63:0] data;
      int          due;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   mem_req_default_t [1:0] mem_req;
   mem_rsp_default_t [1:0] mem_rsp [NumLat];
   logic                   sram_req   [NumLat];
   logic                   sram_we    [NumLat];
   logic [9:0]             sram_addr  [NumLat];
   logic [63:0]            sram_wdata [NumLat];
   logic [7:0]             sram_be    [NumLat];
   logic [63:0]            sram_rdata [NumLat];

   int          cycle        = 0;
   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [63:0] ref_mem [1024];
   exp_t        exp_q [NumLat*2][$];
   logic        pend_valid [2];
   mem_req_q_t  pend_q [2];
   int          last_grant = 1;

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   for (genvar g = 0; g < NumLat; g++) begin : g_lat
      logic [63:0] sram_mem [1024];
      logic [63:0] rd_pipe [g+1];

      mem_sram_port_arbiter #(
         .mem_req_t     (mem_req_default_t),
         .mem_rsp_t     (mem_rsp_default_t),
         .NumPorts      (2),
         .AddrWidth     (32),
         .DataWidth     (64),
         .SramAddrWidth (10),
         .SramLatency   (g + 1)
      ) u_dut (
         .clk_i        (clk),
         .rst_i        (rst),
         .mem_req_i    (mem_req),
         .mem_rsp_o    (mem_rsp[g]),
         .sram_req_o   (sram_req[g]),
         .sram_we_o    (sram_we[g]),
         .sram_addr_o  (sram_addr[g]),
         .sram_wdata_o (sram_wdata[g]),
         .sram_be_o    (sram_be[g]),
         .sram_rdata_i (sram_rdata[g])
      );

      initial begin
         for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
      end

      // Behavioural macro: byte-enabled writes, reads delivered g+1 cycles later.
      always @(posedge clk) begin
         if (sram_req[g] && sram_we[g]) begin
            for (int b = 0; b < 8; b++) begin
               if (sram_be[g][b]) sram_mem[sram_addr[g]][b*8 +: 8] <= sram_wdata[g][b*8 +: 8];
            end
         end
         rd_pipe[0] <= (sram_req[g] && !sram_we[g]) ? sram_mem[sram_addr[g]] : 64'h0BAD_F00D_0BAD_F00D;
         for (int k = 1; k <= g; k++) rd_pipe[k] <= rd_pipe[k-1];
      end

      assign sram_rdata[g] = rd_pipe[g];
   end

   task automatic compare(input string name, input int lat, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s lat=%0d cycle=%0d: got %h, expected %h", name, lat, cycle, act, exp);
      end
   endtask

   task automatic setReq(input int p, input logic [31:0] addr, input logic write,
                         input logic [63:0] data, input logic [7:0] strb);
      pend_valid[p]   = 1'b1;
      pend_q[p].addr  = addr;
      pend_q[p].write = write;
      pend_q[p].data  = data;
      pend_q[p].strb  = strb;
   endtask

   // Reference: round-robin from last grant + 1, memory as a plain word array.
   task automatic checkOutput();
      int          gp;
      logic [9:0]  waddr;
      logic [63:0] rdata;
      exp_t        e;
      gp = -1;
      if (!rst) begin
         for (int k = 1; k <= 2; k++) begin
            if (gp < 0 && pend_valid[(last_grant + k) % 2]) gp = (last_grant + k) % 2;
         end
      end
      for (int d = 0; d < NumLat; d++) begin
         for (int p = 0; p < 2; p++) begin
            compare($sformatf("q_ready[%0d]", p), d + 1, mem_rsp[d][p].q_ready, gp == p);
         end
         compare("sram_req", d + 1, sram_req[d], gp >= 0);
         if (gp >= 0) begin
            compare("sram_we", d + 1, sram_we[d], pend_q[gp].write);
            compare("sram_addr", d + 1, sram_addr[d], pend_q[gp].addr[12:3]);
            compare("sram_wdata", d + 1, sram_wdata[d], pend_q[gp].data);
            compare("sram_be", d + 1, sram_be[d], pend_q[gp].write ? pend_q[gp].strb : 8'hFF);
         end else begin
            compare("idle_we", d + 1, sram_we[d], 1'b0);
            compare("idle_addr", d + 1, sram_addr[d], 10'h0);
            compare("idle_wdata", d + 1, sram_wdata[d], 64'h0);
            compare("idle_be", d + 1, sram_be[d], 8'h0);
         end
      end
      if (gp >= 0) begin
         waddr = pend_q[gp].addr[12:3];
         if (pend_q[gp].write) begin
            for (int b = 0; b < 8; b++) begin
               if (pend_q[gp].strb[b]) ref_mem[waddr][b*8 +: 8] = pend_q[gp].data[b*8 +: 8];
            end
            rdata = '0;
         end else begin
            rdata = ref_mem[waddr];
         end
         for (int d = 0; d < NumLat; d++) begin
            e.data = rdata;
            e.due  = cycle + d + 1;
            exp_q[d*2 + gp].push_back(e);
         end
         pend_valid[gp] = 1'b0;
         last_grant     = gp;
      end
      if (rst) last_grant = 1;
   endtask

   task automatic applyStimulus(input logic rst_val);
      @(posedge clk);
      #1;
      rst = rst_val;
      if (rst_val) begin
         for (int i = 0; i < NumLat*2; i++) exp_q[i].delete();
      end
      for (int p = 0; p < 2; p++) begin
         mem_req[p].q_valid = pend_valid[p];
         mem_req[p].q       = pend_valid[p] ? pend_q[p] : '0;
      end
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0);
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while ((pend_valid[0] || pend_valid[1]) && n < max_cycles) begin
         applyStimulus(1'b0);
         n++;
      end
   endtask

   task automatic monitorCycle();
      exp_t e;
      int   qi;
      for (int d = 0; d < NumLat; d++) begin
         for (int p = 0; p < 2; p++) begin
            qi = d*2 + p;
            while (exp_q[qi].size() > 0 && exp_q[qi][0].due < cycle) begin
               e = exp_q[qi].pop_front();
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL rsp_missing lat=%0d port=%0d: got no response, expected one at cycle %0d",
                        d + 1, p, e.due);
            end
            if (mem_rsp[d][p].p.valid === 1'b1) begin
               if (exp_q[qi].size() == 0) begin
                  tests_run++;
                  tests_failed++;
                  $display("[TB] FAIL rsp_unexpected lat=%0d port=%0d cycle=%0d: got valid with data %h, expected none",
                           d + 1, p, cycle, mem_rsp[d][p].p.data);
               end else begin
                  e = exp_q[qi].pop_front();
                  compare($sformatf("rsp_cycle[%0d]", p), d + 1, 64'(cycle), 64'(e.due));
                  compare($sformatf("rsp_data[%0d]", p), d + 1, mem_rsp[d][p].p.data, e.data);
               end
            end else begin
               compare($sformatf("rsp_quiet_data[%0d]", p), d + 1, mem_rsp[d][p].p.data, 64'h0);
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         monitorCycle();
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      for (int p = 0; p < 2; p++) begin
         pend_valid[p] = 1'b0;
         pend_q[p]     = '0;
      end
      mem_req = '0;

      repeat (3) applyStimulus(1'b1);

      // Full write then read-back of the same word.
      setReq(0, 32'h40, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
      applyStimulus(1'b0);
      setReq(0, 32'h40, 1'b0, 64'h0, 8'h00);
      applyStimulus(1'b0);
      idle(3);

      // Lower-half strobe onto a zero word.
      setReq(0, 32'h80, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      applyStimulus(1'b0);
      setReq(0, 32'h80, 1'b0, 64'h0, 8'h00);
      applyStimulus(1'b0);
      idle(3);

      // Contention straight after reset: both ports request continuously.
      applyStimulus(1'b1);
      for (int k = 0; k < 6; k++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend_valid[p]) setReq(p, 32'h100 * (p + 1) + 32'(k * 8), 1'b1, {$urandom, $urandom}, 8'hFF);
         end
         applyStimulus(1'b0);
      end
      drain(4);
      idle(4);

      // Aliased address, followed by idle cycles.
      setReq(0, 32'h2000, 1'b0, 64'h0, 8'h00);
      applyStimulus(1'b0);
      idle(4);

      // Two reads in flight, then reset; port 0 must win afterwards.
      setReq(1, 32'h208, 1'b0, 64'h0, 8'h00);
      applyStimulus(1'b0);
      setReq(0, 32'h108, 1'b0, 64'h0, 8'h00);
      applyStimulus(1'b0);
      setReq(0, 32'h110, 1'b0, 64'h0, 8'h00);
      setReq(1, 32'h210, 1'b0, 64'h0, 8'h00);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      idle(5);

      // Random traffic over a small aliased window, with occasional resets.
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend_valid[p] && $urandom_range(0, 99) < 60) begin
               setReq(p, ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 3) | ($urandom & 32'h7),
                      1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom));
            end
         end
         applyStimulus($urandom_range(0, 99) == 0);
      end
      drain(4);
      idle(6);

      for (int i = 0; i < NumLat*2; i++) begin
         compare($sformatf("queue_empty[%0d]", i % 2), i / 2 + 1, 64'(exp_q[i].size()), 64'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
